pc_sequencer: RTL and testbench

Program-counter sequencer for the 8-bit MIPS datapath: holds the fetch PC, drives the instruction-memory request/acknowledge handshake, and consumes redirects from the jump-address and branch-target stages, which are the only producers of non-sequential targets. It turns redirects into PC loads and fetch flushes, and reports each delivered instruction with its address to decode.

---
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/pc_sequencer.sv | 127 ++++++++++++
 tb/tb_pc_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch-side bundle of pc_sequencer: stall/redirect inputs, imem handshake and decode outputs.
// Latency: none (wires only); timing is defined by the sequencer.
// Backpressure: ImemAck gates PC advance; Stall prevents new requests.
interface pc_sequencer_if;
  logic       Stall;
  logic       Jump;
  logic [5:0] JumpIn;
  logic       Branch;
  logic [7:0] BranchOff;
  logic       ImemAck;
  logic       ImemReq;
  logic [7:0] PC;
  logic [7:0] PCNext;
  logic       InstrValid;
  logic [7:0] InstrPC;
  logic       Flush;

  // Sequencer side
  modport master (
    input  Stall, Jump, JumpIn, Branch, BranchOff, ImemAck,
    output ImemReq, PC, PCNext, InstrValid, InstrPC, Flush
  );

  // Environment side (control, memory and decode)
  modport slave (
    output Stall, Jump, JumpIn, Branch, BranchOff, ImemAck,
    input  ImemReq, PC, PCNext, InstrValid, InstrPC, Flush
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch PC, imem req/ack handshake, jump/branch redirects, flush.
// Latency: InstrValid/InstrPC/Flush one cycle after the acked edge; PC equals target one cycle after apply.
// Backpressure: PC frozen while ImemReq is high and unacked; Stall blocks new requests. Macro PC_DELAY_SLOT_EN.
module pc_sequencer #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic           Clk,
  input  logic           Reset,
  pc_sequencer_if.master bus
);

`ifdef PC_DELAY_SLOT_EN
  // Instruction acked together with a redirect is a delay slot and is delivered
  localparam logic DELAY_SLOT = 1'b1;
`else
  // Instruction acked together with a redirect is squashed
  localparam logic DELAY_SLOT = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_REQ} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_pc, w_pc_nxt;
  logic       r_pend_vld, w_pend_vld_nxt;
  logic [7:0] r_pend_tgt, w_pend_tgt_nxt;
  logic       r_instr_vld, w_instr_vld_nxt;
  logic [7:0] r_instr_pc, w_instr_pc_nxt;
  logic       r_flush, w_flush_nxt;

  logic [7:0] w_pc_plus4;
  logic [7:0] w_jump_tgt;
  logic [7:0] w_branch_tgt;
  logic       w_redir;
  logic [7:0] w_redir_tgt;
  logic       w_apply;
  logic [7:0] w_apply_tgt;
  logic       w_unused_bits;

  // Targets are always formed from PCNext; PC cannot move while a request is open,
  // so the value seen at capture is the one belonging to the outstanding fetch.
  assign w_pc_plus4   = r_pc + 8'd4;
  assign w_jump_tgt   = {w_pc_plus4[7:6], bus.JumpIn[5:2], 2'b00};
  assign w_branch_tgt = w_pc_plus4 + {bus.BranchOff[5:0], 2'b00};
  assign w_redir      = bus.Jump | bus.Branch;
  assign w_redir_tgt  = bus.Jump ? w_jump_tgt : w_branch_tgt;

  // Bits outside the usable offset/jump fields carry no information here
  assign w_unused_bits = ^{bus.BranchOff[7:6], bus.JumpIn[1:0]};

  // A held redirect takes precedence over a fresh one at the acknowledge
  assign w_apply     = r_pend_vld | w_redir;
  assign w_apply_tgt = r_pend_vld ? r_pend_tgt : w_redir_tgt;

  // Next-state, PC, pending-redirect and delivery decisions
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pend_vld_nxt  = r_pend_vld;
    w_pend_tgt_nxt  = r_pend_tgt;
    w_instr_vld_nxt = 1'b0;
    w_instr_pc_nxt  = r_instr_pc;
    w_flush_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Nothing in flight, so a redirect loads the PC directly
        if (w_redir) begin
          w_pc_nxt    = w_redir_tgt;
          w_flush_nxt = 1'b1;
        end
        if (!bus.Stall) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (bus.ImemAck) begin
          w_instr_pc_nxt = r_pc;
          w_pend_vld_nxt = 1'b0;
          if (w_apply) begin
            w_pc_nxt        = w_apply_tgt;
            w_flush_nxt     = 1'b1;
            w_instr_vld_nxt = DELAY_SLOT;
          end else begin
            w_pc_nxt        = w_pc_plus4;
            w_instr_vld_nxt = 1'b1;
          end
          w_state_nxt = bus.Stall ? S_IDLE : S_REQ;
        end else if (w_redir && !r_pend_vld) begin
          // First redirect wins until it is applied
          w_pend_vld_nxt = 1'b1;
          w_pend_tgt_nxt = w_redir_tgt;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // PC, pending redirect and registered decode outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc        <= RESET_PC;
      r_pend_vld  <= 1'b0;
      r_pend_tgt  <= 8'h00;
      r_instr_vld <= 1'b0;
      r_instr_pc  <= 8'h00;
      r_flush     <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_pend_vld  <= w_pend_vld_nxt;
      r_pend_tgt  <= w_pend_tgt_nxt;
      r_instr_vld <= w_instr_vld_nxt;
      r_instr_pc  <= w_instr_pc_nxt;
      r_flush     <= w_flush_nxt;
    end
  end

  assign bus.ImemReq    = (r_state == S_REQ);
  assign bus.PC         = r_pc;
  assign bus.PCNext     = w_pc_plus4;
  assign bus.InstrValid = r_instr_vld;
  assign bus.InstrPC    = r_instr_pc;
  assign bus.Flush      = r_flush;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed test-plan sequences plus random stimulus vs a queue scoreboard.
// Latency: expected delivery/flush events are stamped with the cycle they must appear in.
// Backpressure: ImemAck and Stall are randomised to exercise held requests and idle redirects.
module tb_pc_sequencer;
  localparam logic [7:0] RESET_PC = 8'h00;
`ifdef PC_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic Clk   = 1'b0;
  logic Reset = 1'b1;

  pc_sequencer_if bus();

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int cyc;
    bit vld;
    bit flush;
    int ipc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc   = 0;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Reference model: is a fetch outstanding, fetch address, held redirect (-1 = none)
  bit m_fetch = 1'b0;
  int m_pc    = int'(RESET_PC);
  int m_pend  = -1;
  bit m_rst   = 1'b1;

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: whenever the DUT shows a delivery or flush (or one is due), compare with the queue head
  initial begin
    forever begin
      bit  has_exp;
      bit  has_dut;
      ev_t e;
      @(posedge Clk);
      #2;
      has_exp = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      has_dut = bus.InstrValid || bus.Flush;
      if (has_exp || has_dut) begin
        check("event_present", int'(has_dut), int'(has_exp));
        if (has_exp) begin
          e = exp_q.pop_front();
          check("InstrValid", int'(bus.InstrValid), int'(e.vld));
          check("Flush", int'(bus.Flush), int'(e.flush));
          if (e.vld) check("InstrPC", int'(bus.InstrPC), e.ipc);
        end
      end
    end
  end

  task automatic push_ev(input bit vld, input bit flush, input int ipc);
    ev_t e;
    e.cyc   = cyc + 1;
    e.vld   = vld;
    e.flush = flush;
    e.ipc   = ipc;
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: check state left by the last edge, drive inputs, advance the model
  task automatic step(input bit rst, input bit st, input bit j, input bit [5:0] ji,
                      input bit b, input bit [7:0] bo, input bit ack);
    int nxt;
    int tgt;
    int red;
    @(negedge Clk);
    check("PC", int'(bus.PC), m_pc);
    check("ImemReq", int'(bus.ImemReq), int'(m_fetch));
    check("PCNext", int'(bus.PCNext), (m_pc + 4) % 256);
    if (m_rst) begin
      check("reset_InstrPC", int'(bus.InstrPC), 0);
      check("reset_InstrValid", int'(bus.InstrValid), 0);
      check("reset_Flush", int'(bus.Flush), 0);
    end
    Reset         = rst;
    bus.Stall     = st;
    bus.Jump      = j;
    bus.JumpIn    = ji;
    bus.Branch    = b;
    bus.BranchOff = bo;
    bus.ImemAck   = ack;
    m_rst = rst;
    if (rst) begin
      m_fetch = 1'b0;
      m_pc    = int'(RESET_PC);
      m_pend  = -1;
    end else begin
      nxt = (m_pc + 4) % 256;
      if (j) tgt = (nxt & 'hC0) | (int'(ji) & 'h3C);
      else   tgt = (nxt + (int'(bo) & 'h3F) * 4) % 256;
      if (!m_fetch) begin
        if (j || b) begin
          m_pc = tgt;
          push_ev(1'b0, 1'b1, 0);
        end
        m_fetch = !st;
      end else if (ack) begin
        red = (m_pend >= 0) ? m_pend : ((j || b) ? tgt : -1);
        push_ev((red < 0) || DS, red >= 0, m_pc);
        m_pc    = (red >= 0) ? red : nxt;
        m_pend  = -1;
        m_fetch = !st;
      end else if ((j || b) && m_pend < 0) begin
        m_pend = tgt;
      end
    end
  endtask

  initial begin
    bus.Stall     = 1'b0;
    bus.Jump      = 1'b0;
    bus.JumpIn    = 6'h00;
    bus.Branch    = 1'b0;
    bus.BranchOff = 8'h00;
    bus.ImemAck   = 1'b0;

    // Back-to-back fetch out of reset: 00,04,08,0C
    step(1, 0, 0, 6'h00, 0, 8'h00, 1);
    repeat (4) step(0, 0, 0, 6'h00, 0, 8'h00, 1);
    // Held request with Stall high, then ack drops to IDLE
    repeat (3) step(0, 1, 0, 6'h00, 0, 8'h00, 0);
    step(0, 1, 0, 6'h00, 0, 8'h00, 1);
    // Jump with same-cycle ack
    step(0, 0, 0, 6'h00, 0, 8'h00, 0);
    step(0, 0, 0, 6'h00, 0, 8'h00, 0);
    step(0, 0, 1, 6'h20, 0, 8'h00, 1);
    // Branch -4 held pending, later jump ignored, applied at ack
    step(0, 0, 0, 6'h00, 1, 8'hFC, 0);
    step(0, 0, 1, 6'h3C, 0, 8'h00, 0);
    step(0, 0, 0, 6'h00, 0, 8'h00, 1);
    // Jump and Branch together in IDLE; jump wins
    step(0, 1, 0, 6'h00, 0, 8'h00, 1);
    step(0, 1, 1, 6'h0C, 1, 8'h10, 0);
    step(0, 0, 0, 6'h00, 0, 8'h00, 0);
    // Reset with a pending redirect outstanding
    step(0, 0, 0, 6'h00, 1, 8'h08, 0);
    step(1, 0, 0, 6'h00, 0, 8'h00, 1);
    step(0, 1, 0, 6'h00, 0, 8'h00, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0,
           6'($urandom),
           $urandom_range(0, 7) == 0,
           8'($urandom),
           $urandom_range(0, 1) == 1);
    end

    // Drain: stop fetching and let outstanding events appear
    repeat (4) step(0, 1, 0, 6'h00, 0, 8'h00, 1);
    @(negedge Clk);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
